window3x3_line_buffer: RTL and testbench
========================================

Name: window3x3_line_buffer

Overview:
- Streaming 3x3 neighbourhood generator that sits directly upstream of the kernel-application (Robinson compass / general 3x3 convolution) stage.
- Accepts a raster-order 8-bit pixel stream and emits exactly one 3x3 window per pixel position, in raster order of the window centre.
- Each window carries centre coordinates and a border flag; the convolver forces border results to 0 (zero-padding rule), so border windows carry all-zero taps.

Parameters:
- ROWS, 242, image height in pixels (>=3).
- COLS, 247, image width in pixels (>=3).
- DATA_W, 8, pixel width; unsigned.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  block accepts pixel this cycle.
- in_pixel  in  DATA_W  raster-order pixel.
- out_valid  out  1  window valid.
- out_ready  in  1  downstream accepts window.
- out_window  out  9*DATA_W  taps; tap (ki,kj) at bits [(ki*3+kj)*DATA_W +: DATA_W], ki = row 0..2 (top first), kj = col 0..2 (left first).
- out_border  out  1  centre on row 0, row ROWS-1, col 0 or col COLS-1.
- out_row  out  16  centre row.
- out_col  out  16  centre column.
- out_last  out  1  window for centre (ROWS-1, COLS-1).

Behaviour:
- Reset (sync, rst=1 at rising edge): out_valid=0, out_window=0, out_border=0, out_row=0, out_col=0, out_last=0. Input counters cleared, state=RUN. Line-buffer contents are undefined and unused.
- Transfers: input fires on in_valid&&in_ready; output fires on out_valid&&out_ready. There is a single output register. out_* stays stable while out_valid&&!out_ready.
- Storage: two line buffers of COLS x DATA_W hold rows r-1 and r-2. A 3x3 tap register shifts one column per accepted pixel.
- Input index n = r*COLS+c, where r,c are the row and column counters of the accepted pixel. N = ROWS*COLS.
- States:
  - RUN:
    - in_ready = !out_valid || out_ready.
    - Each accepted pixel (r,c) writes column {row r-2, row r-1, new pixel} into the tap shift and updates the line buffers.
    - If n >= COLS+1, load output register with window centred at n-COLS-1 in the same cycle. Output is visible the next cycle (latency 1 cycle after the enabling input fire).
    - After accepting n = N-1, go to FLUSH.
  - FLUSH:
    - in_ready = 0.
    - Emits the remaining COLS+1 windows (centres N-COLS-1 .. N-1), all border; one is loaded whenever !out_valid || out_ready.
    - After the window with out_last=1 is loaded, return to RUN with counters zeroed. This allows a back-to-back next frame with no idle cycle beyond the handshake.
- Window content:
  - Interior centre (R,C): tap(ki,kj) = pixel(R-1+ki, C-1+kj).
  - Border centre: all taps 0 and out_border=1.
  - Output count per frame is exactly N, in raster order; out_last is asserted only on centre (ROWS-1, COLS-1).
- Column wrap: the tap shift register is not flushed across row boundaries. Windows whose centre column is 0 or COLS-1 are border, so stale columns are never exposed.
- Simultaneous output fire and new load in the same cycle: the register takes the new window with no bubble, giving full throughput of 1 window/cycle.
- rst mid-frame or mid-FLUSH: immediately returns to the reset state. The partial frame is discarded and the next accepted pixel is treated as (0,0).
- Input pixels with in_valid=0 are ignored. Counters advance only on input fire, and in FLUSH only on output load.

Test Plan:
- ROWS=4, COLS=5, pixel = n, continuous valid/ready -> exactly 20 windows, centres in raster order. Centre (1,1) taps = {0,1,2,5,6,7,10,11,12}; centre (2,3) taps = {7,8,9,12,13,14,17,18,19}; all 14 edge centres have border=1 with zero taps; out_last only on (3,4).
- Same frame with out_ready toggled by a random 50% pattern -> identical window sequence. out_* stable while stalled; in_ready=0 whenever out_valid&&!out_ready.
- Default 242x247 with pixel = (r*7+c*3) mod 256 -> compare every interior window against a software 3x3 gather. Count = 59774 windows; first interior window at centre (1,1) appears after input n=2*247+2 fires.
- Two back-to-back frames with different ramps -> second frame windows contain no data from the first frame. FLUSH lasts exactly COLS+1 output loads under constant out_ready.
- rst asserted for one cycle after 13 pixels of a 4x5 frame, then a full frame -> out_valid=0 the cycle after rst; next 20 windows match the clean-frame expectation.
- in_valid gaps (1 pixel every 3 cycles) -> same window sequence; out_valid never asserted without a preceding enabling input fire or FLUSH load.

Source files
------------

// File: rtl/window3x3_line_buffer.sv
// Streaming 3x3 window generator: two line buffers plus a two-column tap shift feed one
// output register carrying taps, centre coordinates, border and end-of-frame flags.
module window3x3_line_buffer #(
    parameter int unsigned ROWS   = 242,
    parameter int unsigned COLS   = 247,
    parameter int unsigned DATA_W = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [DATA_W-1:0]   in_pixel_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [9*DATA_W-1:0] out_window_o,
    output logic                out_border_o,
    output logic [15:0]         out_row_o,
    output logic [15:0]         out_col_o,
    output logic                out_last_o
);

    localparam int unsigned RowW = $clog2(ROWS);
    localparam int unsigned ColW = $clog2(COLS);
    localparam logic [RowW-1:0] RowLast = RowW'(ROWS - 1);
    localparam logic [ColW-1:0] ColLast = ColW'(COLS - 1);

    typedef enum logic {StRun, StFlush} state_e;

    state_e state_q, state_d;

    // Input position (row/col of the next accepted pixel) and next window centre to load.
    logic [RowW-1:0] in_row_q, in_row_d, ctr_row_q, ctr_row_d;
    logic [ColW-1:0] in_col_q, in_col_d, ctr_col_q, ctr_col_d;

    logic [DATA_W-1:0] lb1_q [COLS];
    logic [DATA_W-1:0] lb2_q [COLS];
    logic [DATA_W-1:0] tap_a_q [3];
    logic [DATA_W-1:0] tap_b_q [3];
    logic [DATA_W-1:0] new_col [3];

    logic                out_valid_q, out_valid_d;
    logic [9*DATA_W-1:0] out_window_q, out_window_d;
    logic                out_border_q, out_border_d;
    logic [15:0]         out_row_q, out_row_d;
    logic [15:0]         out_col_q, out_col_d;
    logic                out_last_q, out_last_d;

    logic                can_load, in_fire, in_last, past_first, load;
    logic                ctr_last, ctr_border;
    logic [9*DATA_W-1:0] win_new;

    always_comb begin
        can_load   = !out_valid_q || out_ready_i;
        in_ready_o = (state_q == StRun) && can_load;
        in_fire    = in_valid_i && in_ready_o;
        in_last    = (in_row_q == RowLast) && (in_col_q == ColLast);
        // n >= COLS+1: the pixel completes the bottom-right tap of some window.
        past_first = (in_row_q > RowW'(1)) || ((in_row_q == RowW'(1)) && (in_col_q != '0));
        load       = (state_q == StRun) ? (in_fire && past_first) : can_load;
        ctr_last   = (ctr_row_q == RowLast) && (ctr_col_q == ColLast);
        ctr_border = (ctr_row_q == '0) || (ctr_row_q == RowLast) ||
                     (ctr_col_q == '0) || (ctr_col_q == ColLast);

        new_col[0] = lb2_q[in_col_q];
        new_col[1] = lb1_q[in_col_q];
        new_col[2] = in_pixel_i;

        win_new = '0;
        for (int ki = 0; ki < 3; ki++) begin
            win_new[(ki*3+0)*DATA_W +: DATA_W] = tap_a_q[ki];
            win_new[(ki*3+1)*DATA_W +: DATA_W] = tap_b_q[ki];
            win_new[(ki*3+2)*DATA_W +: DATA_W] = new_col[ki];
        end
    end

    always_comb begin
        state_d      = state_q;
        in_row_d     = in_row_q;
        in_col_d     = in_col_q;
        ctr_row_d    = ctr_row_q;
        ctr_col_d    = ctr_col_q;
        out_valid_d  = out_valid_q && !out_ready_i;
        out_window_d = out_window_q;
        out_border_d = out_border_q;
        out_row_d    = out_row_q;
        out_col_d    = out_col_q;
        out_last_d   = out_last_q;

        if (load) begin
            out_valid_d  = 1'b1;
            out_window_d = ctr_border ? '0 : win_new;
            out_border_d = ctr_border;
            out_row_d    = 16'(ctr_row_q);
            out_col_d    = 16'(ctr_col_q);
            out_last_d   = ctr_last;
            if (ctr_last) begin
                ctr_row_d = '0;
                ctr_col_d = '0;
                state_d   = StRun;
            end else if (ctr_col_q == ColLast) begin
                ctr_col_d = '0;
                ctr_row_d = ctr_row_q + RowW'(1);
            end else begin
                ctr_col_d = ctr_col_q + ColW'(1);
            end
        end

        if (in_fire) begin
            if (in_last) begin
                in_row_d = '0;
                in_col_d = '0;
                state_d  = StFlush;
            end else if (in_col_q == ColLast) begin
                in_col_d = '0;
                in_row_d = in_row_q + RowW'(1);
            end else begin
                in_col_d = in_col_q + ColW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StRun;
            in_row_q     <= '0;
            in_col_q     <= '0;
            ctr_row_q    <= '0;
            ctr_col_q    <= '0;
            out_valid_q  <= 1'b0;
            out_window_q <= '0;
            out_border_q <= 1'b0;
            out_row_q    <= '0;
            out_col_q    <= '0;
            out_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_row_q     <= in_row_d;
            in_col_q     <= in_col_d;
            ctr_row_q    <= ctr_row_d;
            ctr_col_q    <= ctr_col_d;
            out_valid_q  <= out_valid_d;
            out_window_q <= out_window_d;
            out_border_q <= out_border_d;
            out_row_q    <= out_row_d;
            out_col_q    <= out_col_d;
            out_last_q   <= out_last_d;
        end
    end

    // Storage only ever feeds interior windows, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (in_fire) begin
            lb1_q[in_col_q] <= in_pixel_i;
            lb2_q[in_col_q] <= new_col[1];
            for (int k = 0; k < 3; k++) begin
                tap_a_q[k] <= tap_b_q[k];
                tap_b_q[k] <= new_col[k];
            end
        end
    end

    assign out_valid_o  = out_valid_q;
    assign out_window_o = out_window_q;
    assign out_border_o = out_border_q;
    assign out_row_o    = out_row_q;
    assign out_col_o    = out_col_q;
    assign out_last_o   = out_last_q;

endmodule

// File: tb/tb_window3x3_line_buffer.sv
// Scoreboard bench: a small 4x5 instance for directed handshake/reset cases and a
// default-size instance checked against a software 3x3 gather.
module tb_window3x3_line_buffer;

    localparam int SR = 4;
    localparam int SC = 5;
    localparam int SN = SR * SC;
    localparam int BR = 242;
    localparam int BC = 247;
    localparam int BN = BR * BC;

    typedef struct packed {
        logic [71:0] win;
        logic        border;
        logic [15:0] row;
        logic [15:0] col;
        logic        last;
    } win_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        s_rst, s_in_valid, s_in_ready, s_out_valid, s_out_border, s_out_last;
    logic        s_out_ready = 1'b1;
    logic [7:0]  s_in_pixel;
    logic [71:0] s_out_window;
    logic [15:0] s_out_row, s_out_col;

    logic        b_rst, b_in_valid, b_in_ready, b_out_valid, b_out_border, b_out_last;
    logic        b_out_ready;
    logic [7:0]  b_in_pixel;
    logic [71:0] b_out_window;
    logic [15:0] b_out_row, b_out_col;

    int   n_cmp = 0;
    int   n_err = 0;
    win_t s_q[$];
    win_t b_q[$];
    bit   rnd_ready = 1'b0;
    bit   b_run = 1'b0;
    int   b_n = 0;
    int   b_cnt = 0;

    window3x3_line_buffer #(.ROWS(SR), .COLS(SC), .DATA_W(8)) u_small (
        .clk_i(clk), .rst_i(s_rst), .in_valid_i(s_in_valid), .in_ready_o(s_in_ready),
        .in_pixel_i(s_in_pixel), .out_valid_o(s_out_valid), .out_ready_i(s_out_ready),
        .out_window_o(s_out_window), .out_border_o(s_out_border), .out_row_o(s_out_row),
        .out_col_o(s_out_col), .out_last_o(s_out_last)
    );

    window3x3_line_buffer u_big (
        .clk_i(clk), .rst_i(b_rst), .in_valid_i(b_in_valid), .in_ready_o(b_in_ready),
        .in_pixel_i(b_in_pixel), .out_valid_o(b_out_valid), .out_ready_i(b_out_ready),
        .out_window_o(b_out_window), .out_border_o(b_out_border), .out_row_o(b_out_row),
        .out_col_o(b_out_col), .out_last_o(b_out_last)
    );

    function automatic logic [7:0] pix(input int mode, input int r, input int c, input int cols);
        int v;
        case (mode)
            0:       v = r * cols + c;
            1:       v = (r * cols + c) * 3 + 100;
            default: v = r * 7 + c * 3;
        endcase
        return v[7:0];
    endfunction

    function automatic win_t exp_win(input int mode, input int rows, input int cols,
                                     input int r, input int c);
        win_t e;
        e        = '0;
        e.row    = r[15:0];
        e.col    = c[15:0];
        e.last   = (r == rows - 1) && (c == cols - 1);
        e.border = (r == 0) || (r == rows - 1) || (c == 0) || (c == cols - 1);
        if (!e.border)
            for (int ki = 0; ki < 3; ki++)
                for (int kj = 0; kj < 3; kj++)
                    e.win[(ki*3+kj)*8 +: 8] = pix(mode, r - 1 + ki, c - 1 + kj, cols);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input bit big, input int mode, input int rows, input int cols,
                              input int count);
        for (int m = 0; m < count; m++) begin
            if (big) b_q.push_back(exp_win(mode, rows, cols, m / cols, m % cols));
            else     s_q.push_back(exp_win(mode, rows, cols, m / cols, m % cols));
        end
    endtask

    task automatic drive_frame(input int mode, input int npix, input int gap, input bit flush_chk);
        bit fired;
        int cnt;
        for (int n = 0; n < npix; n++) begin
            fired      = 1'b0;
            s_in_valid = 1'b1;
            s_in_pixel = pix(mode, n / SC, n % SC, SC);
            for (int k = 0; k < 200 && !fired; k++) begin
                @(negedge clk);
                fired = s_in_ready;
                @(posedge clk);
                #1;
            end
            chk("in_accept", 128'(fired), 1);
            if (!fired) break;
            if (gap > 0) begin
                s_in_valid = 1'b0;
                repeat (gap) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        s_in_valid = 1'b0;
        if (flush_chk) begin
            cnt = 0;
            for (int k = 0; k < 100; k++) begin
                @(negedge clk);
                if (s_in_ready) break;
                cnt++;
            end
            chk("flush_len", 128'(cnt), 128'(SC + 1));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && s_q.size() != 0; k++) @(posedge clk);
        chk("drain", 128'(s_q.size()), 0);
        @(posedge clk);
        #1;
    endtask

    always begin
        @(posedge clk);
        #1;
        s_out_ready <= rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    win_t s_obs, s_prev, b_obs;
    bit   s_prev_stall = 1'b0;
    bit   s_prev_valid = 1'b0;
    bit   s_prev_evt = 1'b0;
    assign s_obs = {s_out_window, s_out_border, s_out_row, s_out_col, s_out_last};
    assign b_obs = {b_out_window, b_out_border, b_out_row, b_out_col, b_out_last};

    always @(negedge clk) begin
        win_t e;
        if (s_prev_stall) chk("stall_hold", 128'(s_obs), 128'(s_prev));
        if (s_out_valid && !s_out_ready) chk("stall_in_ready", 128'(s_in_ready), 0);
        // A rising out_valid needs a fire or a FLUSH cycle (in_ready low with no stall).
        if (s_out_valid && !s_prev_valid) chk("valid_cause", 128'(s_prev_evt), 1);
        if (s_out_valid && s_out_ready) begin
            chk("sb_nonempty", 128'(s_q.size() != 0), 1);
            if (s_q.size() != 0) begin
                e = s_q.pop_front();
                chk("window", 128'(s_obs), 128'(e));
            end
        end
        s_prev_stall <= s_out_valid && !s_out_ready && !s_rst;
        s_prev       <= s_obs;
        s_prev_valid <= s_out_valid;
        s_prev_evt   <= (s_in_valid && s_in_ready) || !s_in_ready;
    end

    assign b_out_ready = 1'b1;
    assign b_in_valid  = b_run && (b_n < BN);
    assign b_in_pixel  = pix(2, b_n / BC, b_n % BC, BC);

    always @(posedge clk) begin
        if (b_rst) b_n <= 0;
        else if (b_in_valid && b_in_ready) b_n <= b_n + 1;
    end

    always @(negedge clk) begin
        win_t e;
        if (b_out_valid) begin
            if (b_out_row == 16'd1 && b_out_col == 16'd1)
                chk("first_interior_n", 128'(b_n), 128'(2 * BC + 3));
            chk("big_sb_nonempty", 128'(b_q.size() != 0), 1);
            if (b_q.size() != 0) begin
                e = b_q.pop_front();
                chk("big_window", 128'(b_obs), 128'(e));
            end
            b_cnt <= b_cnt + 1;
        end
    end

    initial begin
        s_rst      = 1'b1;
        b_rst      = 1'b1;
        s_in_valid = 1'b0;
        s_in_pixel = '0;
        repeat (2) @(posedge clk);
        #1;
        s_rst = 1'b0;
        b_rst = 1'b0;
        @(negedge clk);
        chk("rst_small", 128'({s_out_valid, s_obs}), 0);
        chk("rst_big", 128'({b_out_valid, b_obs}), 0);
        chk("rst_in_ready", 128'(s_in_ready), 1);
        @(posedge clk);
        #1;

        // Clean frame, continuous handshake.
        push_frame(1'b0, 0, SR, SC, SN);
        drive_frame(0, SN, 0, 1'b1);
        drain();

        // Random downstream backpressure.
        rnd_ready = 1'b1;
        push_frame(1'b0, 0, SR, SC, SN);
        drive_frame(0, SN, 0, 1'b0);
        drain();
        rnd_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Back-to-back frames with different ramps.
        push_frame(1'b0, 0, SR, SC, SN);
        push_frame(1'b0, 1, SR, SC, SN);
        drive_frame(0, SN, 0, 1'b1);
        drive_frame(1, SN, 0, 1'b1);
        drain();

        // Reset after 13 pixels, then a clean frame.
        push_frame(1'b0, 0, SR, SC, 13 - SC - 1);
        drive_frame(0, 13, 0, 1'b0);
        s_rst = 1'b1;
        @(posedge clk);
        #1;
        s_rst = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", 128'(s_out_valid), 0);
        chk("post_rst_sb", 128'(s_q.size()), 0);
        @(posedge clk);
        #1;
        push_frame(1'b0, 0, SR, SC, SN);
        drive_frame(0, SN, 0, 1'b0);
        drain();

        // Sparse input: one pixel every three cycles.
        push_frame(1'b0, 0, SR, SC, SN);
        drive_frame(0, SN, 2, 1'b0);
        drain();

        // Full-size frame against the software gather.
        push_frame(1'b1, 2, BR, BC, BN);
        b_run = 1'b1;
        for (int k = 0; k < BN + 2000 && b_cnt < BN; k++) @(posedge clk);
        repeat (10) @(posedge clk);
        chk("big_count", 128'(b_cnt), 128'(BN));
        chk("big_sb_empty", 128'(b_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
